// File: rtl/reg_file_ram.sv
// RV32 storage block: 32x32 integer register file plus word-wide data RAM.
// Combinational reads, single-edge writes, shared synchronous active-low reset.
module reg_file_ram #(
    parameter int RAM_DEPTH_WORDS = 1024,
    parameter int RAM_AW          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ram_addr,
    input  logic [31:0] ram_wdata,
    input  logic        ram_wen,
    output logic [31:0] ram_rdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        WE,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0]       regs_q [32];
    logic [31:0]       mem_q  [RAM_DEPTH_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              reg_we_d;
    logic              ram_we_d;

    // Byte offset and bits above the RAM window are dropped, so accesses
    // are word-aligned and wrap modulo the RAM size.
    assign ram_idx = ram_addr[RAM_AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr[15:RAM_AW+2], ram_addr[1:0]};

    // Write qualifiers: x0 never written, nothing written during reset.
    always_comb begin
        reg_we_d = rst_n && WE && (waddr != 5'd0);
        ram_we_d = rst_n && ram_wen;
    end

    // Register file update: clear all on reset, else single write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (reg_we_d) begin
            regs_q[waddr] <= wdata;
        end
    end

    // RAM update: contents survive reset, full-word writes only.
    always_ff @(posedge clk) begin
        if (ram_we_d) begin
            mem_q[ram_idx] <= ram_wdata;
        end
    end

    // Asynchronous reads; x0 forced to zero regardless of array contents.
    always_comb begin
        rdata1    = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
        rdata2    = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];
        ram_rdata = mem_q[ram_idx];
    end

endmodule

// File: tb/tb_reg_file_ram.sv
// Directed self-checking bench for reg_file_ram.
// Inputs change 1 ns after each rising edge; outputs checked before the next.
module tb_reg_file_ram;

    logic        clk;
    logic        rst_n;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wen;
    logic [31:0] ram_rdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        WE;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    reg_file_ram #(
        .RAM_DEPTH_WORDS(1024),
        .RAM_AW(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wen(ram_wen),
        .ram_rdata(ram_rdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2),
        .WE(WE),
        .waddr(waddr),
        .wdata(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ram_addr  = 16'h0000;
        ram_wdata = 32'h0;
        ram_wen   = 1'b0;
        raddr1    = 5'd0;
        raddr2    = 5'd0;
        WE        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'h0;
        tick();
        tick();
        rst_n  = 1'b1;
        raddr1 = 5'd7;
        raddr2 = 5'd31;
        #1;
        check("reset_rdata1_x7", rdata1, 32'h0);
        check("reset_rdata2_x31", rdata2, 32'h0);

        // RAM write then read-back
        ram_addr  = 16'h0004;
        ram_wdata = 32'h0000_00C8;
        ram_wen   = 1'b1;
        tick();
        ram_wen = 1'b0;
        #1;
        check("ram_readback", ram_rdata, 32'h0000_00C8);
        ram_wdata = 32'hDEAD_BEEF;
        #1;
        check("ram_wdata_no_effect", ram_rdata, 32'h0000_00C8);

        // Load write-back: RAM data into x1
        wdata = ram_rdata;
        waddr = 5'd1;
        WE    = 1'b1;
        tick();
        WE     = 1'b0;
        raddr1 = 5'd0;
        raddr2 = 5'd1;
        #1;
        check("xfer_rdata2_x1", rdata2, 32'h0000_00C8);
        check("xfer_rdata1_x0", rdata1, 32'h0);
        tick();
        check("xfer_hold_x1", rdata2, 32'h0000_00C8);

        // x0 write discarded
        WE    = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0;
        #1;
        check("x0_protect", rdata1, 32'h0);
        check("x0_write_no_side", rdata2, 32'h0000_00C8);

        // Reset clears regs, drops coinciding writes, keeps RAM
        WE    = 1'b1;
        waddr = 5'd5;
        wdata = 32'h1234_5678;
        tick();
        raddr1 = 5'd5;
        #1;
        check("x5_loaded", rdata1, 32'h1234_5678);
        rst_n     = 1'b0;
        wdata     = 32'hAAAA_AAAA;
        ram_addr  = 16'h0004;
        ram_wdata = 32'h0000_0055;
        ram_wen   = 1'b1;
        tick();
        rst_n   = 1'b1;
        WE      = 1'b0;
        ram_wen = 1'b0;
        #1;
        check("reset_clears_x5", rdata1, 32'h0);
        check("reset_clears_x1", rdata2, 32'h0);
        check("reset_keeps_ram", ram_rdata, 32'h0000_00C8);

        // Address aliasing
        ram_addr  = 16'h0008;
        ram_wdata = 32'h1111_1111;
        ram_wen   = 1'b1;
        tick();
        ram_wen  = 1'b0;
        ram_addr = 16'h000B;
        #1;
        check("alias_low_bits", ram_rdata, 32'h1111_1111);
        ram_addr = 16'h1008;
        #1;
        check("alias_wrap", ram_rdata, 32'h1111_1111);
        ram_addr = 16'h0004;
        #1;
        check("alias_neighbour", ram_rdata, 32'h0000_00C8);

        // Read during write
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        waddr  = 5'd3;
        wdata  = 32'h1;
        WE     = 1'b1;
        tick();
        wdata = 32'h2;
        #1;
        check("rdw_old_value", rdata1, 32'h1);
        tick();
        WE = 1'b0;
        check("rdw_new_rdata1", rdata1, 32'h2);
        check("rdw_new_rdata2", rdata2, 32'h2);

        // Simultaneous register and RAM write
        WE        = 1'b1;
        waddr     = 5'd31;
        wdata     = 32'hCAFE_F00D;
        ram_wen   = 1'b1;
        ram_addr  = 16'h0010;
        ram_wdata = 32'h0BAD_F00D;
        raddr1    = 5'd31;
        tick();
        WE      = 1'b0;
        ram_wen = 1'b0;
        #1;
        check("dual_write_reg", rdata1, 32'hCAFE_F00D);
        check("dual_write_ram", ram_rdata, 32'h0BAD_F00D);

        // Mid-cycle reset has no effect before the edge
        rst_n = 1'b0;
        #2;
        check("midcycle_reset", rdata1, 32'hCAFE_F00D);
        rst_n = 1'b1;
        tick();
        check("midcycle_reset_edge", rdata1, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
